// File: rtl/stopwatch_core.sv
// Stopwatch timebase: prescales clk into 0.1 s ticks and counts m:ss.t, with
// run/pause, clear, lap-hold display and wrap-or-saturate overflow handling.
module stopwatch_core #(
    parameter int unsigned TENTH_CYCLES = 5_000_000,
    parameter int unsigned MIN_W        = 7,
    parameter int unsigned MAX_MIN      = 99,
    parameter bit          WRAP         = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    output logic [3:0]       disp_tenth,
    output logic [5:0]       disp_sec,
    output logic [MIN_W-1:0] disp_min,
    output logic             running,
    output logic             lap_hold,
    output logic             tick,
    output logic             ovf
);

    localparam int unsigned PRESC_W = $clog2(TENTH_CYCLES);

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [5:0]       sec;
        logic [3:0]       tenth;
    } time_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_HALT    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    time_t              cnt_q, cnt_d;
    time_t              hold_q, hold_d;
    time_t              disp_q, disp_d;
    logic               lap_hold_q, lap_hold_d;
    logic               tick_q, tick_d;
    logic               ovf_q, ovf_d;
    logic               running_q, running_d;

    logic presc_term;
    logic at_max;
    logic clear_ok;

    assign presc_term = (state_q == S_RUNNING) &&
                        (presc_q == PRESC_W'(TENTH_CYCLES - 1));
    assign at_max     = (cnt_q.min == MIN_W'(MAX_MIN)) &&
                        (cnt_q.sec == 6'd59) && (cnt_q.tenth == 4'd9);
    assign clear_ok   = clear && (state_q != S_RUNNING);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: saturation wins over a coincident start_stop, so HALT ignores it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!clear && start_stop) state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (presc_term && at_max && !WRAP) state_d = S_HALT;
                else if (start_stop)               state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (clear)           state_d = S_IDLE;
                else if (start_stop) state_d = S_RUNNING;
            end
            S_HALT: begin
                if (clear) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        lap_hold_d = lap_hold_q;
        tick_d     = 1'b0;
        ovf_d      = ovf_q;

        if (clear_ok) begin
            presc_d    = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            lap_hold_d = 1'b0;
        end else if (state_q == S_RUNNING) begin
            presc_d = presc_term ? '0 : presc_q + PRESC_W'(1);
            if (presc_term) begin
                tick_d = 1'b1;
                if (at_max) begin
                    if (WRAP) cnt_d = '0;
                    else      ovf_d = 1'b1;
                end else if (cnt_q.tenth != 4'd9) begin
                    cnt_d.tenth = cnt_q.tenth + 4'd1;
                end else begin
                    cnt_d.tenth = 4'd0;
                    if (cnt_q.sec != 6'd59) begin
                        cnt_d.sec = cnt_q.sec + 6'd1;
                    end else begin
                        cnt_d.sec = 6'd0;
                        cnt_d.min = cnt_q.min + MIN_W'(1);
                    end
                end
            end
            // Lap sees the post-increment count; pausing always releases the hold
            if (state_d == S_PAUSED) begin
                lap_hold_d = 1'b0;
            end else if (lap && state_d == S_RUNNING) begin
                if (lap_hold_q) begin
                    lap_hold_d = 1'b0;
                end else begin
                    lap_hold_d = 1'b1;
                    hold_d     = cnt_d;
                end
            end
        end

        disp_d    = lap_hold_d ? hold_d : cnt_d;
        running_d = (state_d == S_RUNNING);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            disp_q     <= '0;
            lap_hold_q <= 1'b0;
            tick_q     <= 1'b0;
            ovf_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            disp_q     <= disp_d;
            lap_hold_q <= lap_hold_d;
            tick_q     <= tick_d;
            ovf_q      <= ovf_d;
            running_q  <= running_d;
        end
    end

    assign disp_tenth = disp_q.tenth;
    assign disp_sec   = disp_q.sec;
    assign disp_min   = disp_q.min;
    assign running    = running_q;
    assign lap_hold   = lap_hold_q;
    assign tick       = tick_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: a wrapping and a saturating instance share stimulus
// and are compared against a total-tenths reference model.
module tb_stopwatch_core;

    localparam int TC   = 4;
    localparam int MW   = 2;
    localparam int MM   = 1;
    localparam int MAXT = (MM * 60 + 59) * 10 + 9;
    localparam int VW   = MW + 14;

    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int HALT  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_stop = 1'b0;
    logic          clear = 1'b0;
    logic          lap = 1'b0;

    logic [3:0]    dt_w, dt_s;
    logic [5:0]    ds_w, ds_s;
    logic [MW-1:0] dm_w, dm_s;
    logic          run_w, run_s, lh_w, lh_s, tick_w, tick_s, ovf_w, ovf_s;

    stopwatch_core #(.TENTH_CYCLES(TC), .MIN_W(MW), .MAX_MIN(MM), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp_tenth(dt_w), .disp_sec(ds_w), .disp_min(dm_w), .running(run_w),
        .lap_hold(lh_w), .tick(tick_w), .ovf(ovf_w)
    );

    stopwatch_core #(.TENTH_CYCLES(TC), .MIN_W(MW), .MAX_MIN(MM), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp_tenth(dt_s), .disp_sec(ds_s), .disp_min(dm_s), .running(run_s),
        .lap_hold(lh_s), .tick(tick_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model, index 0 = wrapping instance, 1 = saturating instance
    int m_t[2];
    int m_ph[2];
    int m_st[2];
    int m_held[2];
    bit m_lh[2];
    bit m_ovf[2];
    bit m_tick[2];

    function automatic logic [VW-1:0] exp_vec(input int k);
        int x;
        x = m_lh[k] ? m_held[k] : m_t[k];
        return {MW'(x / 600), 6'((x / 10) % 60), 4'(x % 10),
                m_st[k] == RUN, m_lh[k], m_tick[k], m_ovf[k]};
    endfunction

    function automatic logic [VW-1:0] obs(input int k);
        if (k == 0) return {dm_w, ds_w, dt_w, run_w, lh_w, tick_w, ovf_w};
        return {dm_s, ds_s, dt_s, run_s, lh_s, tick_s, ovf_s};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_ph[k] = 0; m_st[k] = IDLE; m_held[k] = 0;
            m_lh[k] = 1'b0; m_ovf[k] = 1'b0; m_tick[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit lp);
        for (int k = 0; k < 2; k++) begin
            bit wrap;
            bit term;
            wrap = (k == 0);
            m_tick[k] = 1'b0;
            if (cl && m_st[k] != RUN) begin
                m_t[k] = 0; m_ph[k] = 0; m_ovf[k] = 1'b0; m_lh[k] = 1'b0; m_st[k] = IDLE;
            end else if (m_st[k] == RUN) begin
                term = (m_ph[k] == TC - 1);
                m_ph[k] = term ? 0 : m_ph[k] + 1;
                m_tick[k] = term;
                if (term) begin
                    if (m_t[k] == MAXT) begin
                        if (wrap) m_t[k] = 0;
                        else begin m_ovf[k] = 1'b1; m_st[k] = HALT; end
                    end else begin
                        m_t[k] = m_t[k] + 1;
                    end
                end
                if (m_st[k] == RUN) begin
                    if (ss) begin
                        m_st[k] = PAUSE; m_lh[k] = 1'b0;
                    end else if (lp) begin
                        if (m_lh[k]) m_lh[k] = 1'b0;
                        else begin m_lh[k] = 1'b1; m_held[k] = m_t[k]; end
                    end
                end
            end else if (ss && m_st[k] != HALT) begin
                m_st[k] = RUN;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cycle(input bit ss, input bit cl, input bit lp);
        start_stop = ss; clear = cl; lap = lp;
        @(posedge clk);
        model_step(ss, cl, lp);
        @(negedge clk);
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== '0) $display("FAIL reset_async dut%0d got=%h exp=0", k, obs(k));
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== exp_vec(k)) $display("FAIL reset_idle dut%0d got=%h exp=%h", k, obs(k), exp_vec(k));
            else n_pass++;
        end
    endtask

    task automatic test_count();
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) $display("FAIL count_c%0d dut%0d got=%h exp=%h", i, k, obs(k), exp_vec(k));
                else n_pass++;
            end
            n_checks++;
            if (tick_w !== ((i % TC) == 0)) $display("FAIL tick_period c%0d got=%b exp=%b", i, tick_w, (i % TC) == 0);
            else n_pass++;
        end
        n_checks++;
        if ({ds_w, dt_w} !== {6'd1, 4'd0}) $display("FAIL count_1s got=%0d.%0d exp=1.0", ds_w, dt_w);
        else n_pass++;
    endtask

    task automatic test_pause();
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (9) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({run_w, dt_w} !== {1'b0, 4'd2}) $display("FAIL pause_enter got=%b/%0d exp=0/2", run_w, dt_w);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs(0) !== exp_vec(0) || dt_w !== 4'd2) $display("FAIL pause_frozen c%0d got=%h exp=%h", i, obs(0), exp_vec(0));
            else n_pass++;
        end
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({run_w, tick_w} !== 2'b10) $display("FAIL resume_early got=%b%b exp=10", run_w, tick_w);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({tick_w, dt_w} !== {1'b1, 4'd3} || obs(0) !== exp_vec(0)) $display("FAIL resume_tick got=%b/%0d exp=1/3", tick_w, dt_w);
        else n_pass++;
    endtask

    task automatic test_lap();
        int guard;
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0);
        guard = 0;
        while ((ds_w !== 6'd3 || dt_w !== 4'd0) && guard < 400) begin
            cycle(1'b0, 1'b0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 400 || obs(0) !== exp_vec(0)) $display("FAIL lap_reach3 got=%h exp=%h", obs(0), exp_vec(0));
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({ds_w, dt_w, lh_w} !== {6'd3, 4'd0, 1'b1}) $display("FAIL lap_capture got=%0d.%0d h%b exp=3.0 h1", ds_w, dt_w, lh_w);
        else n_pass++;
        for (int i = 0; i < 79; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs(0) !== exp_vec(0) || ds_w !== 6'd3 || dt_w !== 4'd0) $display("FAIL lap_frozen c%0d got=%h exp=%h", i, obs(0), exp_vec(0));
            else n_pass++;
        end
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({ds_w, dt_w, lh_w} !== {6'd5, 4'd0, 1'b0} || obs(1) !== exp_vec(1)) $display("FAIL lap_release got=%0d.%0d h%b exp=5.0 h0", ds_w, dt_w, lh_w);
        else n_pass++;
    endtask

    task automatic test_priority();
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs(0) !== '0 || obs(0) !== exp_vec(0)) $display("FAIL clear_beats_ss got=%h exp=0", obs(0));
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (run_w !== 1'b1 || dt_w !== 4'd1 || obs(1) !== exp_vec(1)) $display("FAIL clear_ignored_run got=%h exp=%h", obs(1), exp_vec(1));
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== '0) $display("FAIL reset_midrun dut%0d got=%h exp=0", k, obs(k));
            else n_pass++;
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs(0) !== exp_vec(0) || tick_w !== 1'b0) $display("FAIL reset_stays_idle got=%h exp=%h", obs(0), exp_vec(0));
        else n_pass++;
    endtask

    task automatic test_overflow();
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= (MAXT + 1) * TC; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) $display("FAIL ovf_run_c%0d dut%0d got=%h exp=%h", i, k, obs(k), exp_vec(k));
                else n_pass++;
            end
            if (i == MAXT * TC) begin
                n_checks++;
                if ({dm_w, ds_w, dt_w} !== {MW'(1), 6'd59, 4'd9}) $display("FAIL reach_max got=%0d:%0d.%0d exp=1:59.9", dm_w, ds_w, dt_w);
                else n_pass++;
            end
        end
        n_checks++;
        if ({dm_w, ds_w, dt_w, run_w, ovf_w} !== {MW'(0), 6'd0, 4'd0, 1'b1, 1'b0}) $display("FAIL wrap_zero got=%0d:%0d.%0d r%b o%b", dm_w, ds_w, dt_w, run_w, ovf_w);
        else n_pass++;
        n_checks++;
        if ({dm_s, ds_s, dt_s, run_s, ovf_s} !== {MW'(1), 6'd59, 4'd9, 1'b0, 1'b1}) $display("FAIL sat_hold got=%0d:%0d.%0d r%b o%b", dm_s, ds_s, dt_s, run_s, ovf_s);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (run_s !== 1'b0 || ovf_s !== 1'b1 || obs(1) !== exp_vec(1) || obs(0) !== exp_vec(0)) $display("FAIL halt_ignores_ss got=%h exp=%h", obs(1), exp_vec(1));
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== '0 || exp_vec(k) !== '0) $display("FAIL clear_after_max dut%0d got=%h exp=0", k, obs(k));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            bit ss, cl, lp;
            ss = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 31) == 0);
            lp = ($urandom_range(0, 11) == 0);
            cycle(ss, cl, lp);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== exp_vec(k)) $display("FAIL random_c%0d dut%0d got=%h exp=%h", i, k, obs(k), exp_vec(k));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pause();
        test_lap();
        test_priority();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
